// File: rtl/cursor_pkg.sv
// Shared definitions for the mouse report packer: FSM states, byte-0
// bit layout, clamp limit and the tier level that inhibits cursor output.
package cursor_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SNAP = 3'd1,
        B0   = 3'd2,
        B1   = 3'd3,
        B2   = 3'd4
    } state_t;

    // Byte-0 bit positions of a PS/2-style report
    localparam int BTN_L   = 0;
    localparam int BTN_R   = 1;
    localparam int ALWAYS1 = 3;
    localparam int XSIGN   = 4;
    localparam int YSIGN   = 5;

    // Largest magnitude a single report byte carries
    localparam int REPORT_CLAMP = 127;

    // tier at or above this value inhibits cursor output
    localparam logic [1:0] TIER_INHIBIT = 2'd2;

    // Assemble byte 0 from the button vector and the axis sign bits
    function automatic logic [7:0] build_b0(input logic [1:0] btn,
                                            input logic       x_sign,
                                            input logic       y_sign);
        logic [7:0] b;
        b          = 8'h00;
        b[BTN_L]   = btn[0];
        b[BTN_R]   = btn[1];
        b[ALWAYS1] = 1'b1;
        b[XSIGN]   = x_sign;
        b[YSIGN]   = y_sign;
        return b;
    endfunction

endpackage

// File: rtl/sat_axis_accum.sv
// One axis of cursor motion: a signed saturating accumulator that also
// exposes its value clamped to a single report byte. In the snapshot cycle
// the clamped value is removed and any same-cycle sample is added, so
// residual motion carries forward and no sample is lost.
module sat_axis_accum
    import cursor_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_add,
    input  logic signed [7:0]       i_delta,
    input  logic                    i_snap,
    output logic signed [ACC_W-1:0] o_acc,
    output logic signed [7:0]       o_clamp
);

    // Two guard bits hold acc - clamp + delta without overflow
    localparam int EW = ACC_W + 2;
    localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] CLAMP_P = ACC_W'(REPORT_CLAMP);
    localparam logic signed [ACC_W-1:0] CLAMP_N = -CLAMP_P;
    localparam logic signed [7:0] BYTE_P = 8'(REPORT_CLAMP);
    localparam logic signed [7:0] BYTE_N = -BYTE_P;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [7:0]       w_clamp;
    logic signed [EW-1:0]    w_acc_ext;
    logic signed [EW-1:0]    w_sub_ext;
    logic signed [EW-1:0]    w_add_ext;
    logic signed [EW-1:0]    w_sum;
    logic signed [ACC_W-1:0] w_sat;

    // Clamp the accumulator to the symmetric report range
    always_comb begin
        w_clamp = r_acc[7:0];
        if (r_acc > CLAMP_P) begin
            w_clamp = BYTE_P;
        end else if (r_acc < CLAMP_N) begin
            w_clamp = BYTE_N;
        end
    end

    // Combined subtract-on-snapshot and add-on-sample, then saturate
    always_comb begin
        w_acc_ext = {{2{r_acc[ACC_W-1]}}, r_acc};
        w_sub_ext = i_snap ? {{(EW-8){w_clamp[7]}}, w_clamp} : '0;
        w_add_ext = i_add  ? {{(EW-8){i_delta[7]}}, i_delta} : '0;
        w_sum     = w_acc_ext - w_sub_ext + w_add_ext;
        w_sat     = w_sum[ACC_W-1:0];
        if (w_sum > SAT_MAX) begin
            w_sat = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (w_sum < SAT_MIN) begin
            w_sat = {1'b1, {(ACC_W-1){1'b0}}};
        end
    end

    // Accumulator register; inhibit clears and holds it at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_snap || i_add) begin
            r_acc <= w_sat;
        end
    end

    assign o_acc   = r_acc;
    assign o_clamp = w_clamp;

endmodule

// File: rtl/mouse_report_packer.sv
// Packs accumulated cursor motion and click state into 3-byte PS/2-style
// reports on a byte stream. Reports go out on each timer tick when motion
// is pending and immediately on any button change.
//
// Stream handshake: a byte transfers on a rising clk edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready low, m_data and
// m_last hold steady and m_valid stays high. m_last marks byte 2.
module mouse_report_packer
    import cursor_pkg::*;
#(
    parameter int REPORT_CYCLES = 1_000_000,
    parameter int ACC_W         = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] dx,
    input  logic [7:0] dy,
    input  logic       left_click,
    input  logic       right_click,
    input  logic [1:0] tier,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy
);

    localparam int TW = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_TERM = TW'(REPORT_CYCLES - 1);

    state_t                  r_state;
    logic [TW-1:0]           r_timer;
    logic                    r_right_pend;
    logic [1:0]              r_last_btn;
    logic [7:0]              r_ox;
    logic [7:0]              r_oy;
    logic [7:0]              r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic                    r_busy;

    logic                    w_inhibit;
    logic                    w_tick;
    logic                    w_motion;
    logic                    w_trigger;
    logic                    w_snap;
    logic                    w_add;
    logic [1:0]              w_btn;
    logic signed [ACC_W-1:0] w_acc_x;
    logic signed [ACC_W-1:0] w_acc_y;
    logic signed [7:0]       w_clamp_x;
    logic signed [7:0]       w_clamp_y;
    logic signed [7:0]       w_ox;
    logic signed [7:0]       w_oy;
    logic [7:0]              w_b0;

    // Decode inhibit, tick, button vector, trigger and snapshot bytes
    always_comb begin
        w_inhibit = (tier >= TIER_INHIBIT);
        w_tick    = (r_timer == TIMER_TERM);
        w_add     = sample_valid && !w_inhibit;
        w_snap    = (r_state == SNAP);
        w_btn     = w_inhibit ? 2'b00 : {r_right_pend, left_click};
        w_motion  = (w_acc_x != '0) || (w_acc_y != '0);
        w_trigger = (r_state == IDLE) &&
                    ((w_tick && w_motion && !w_inhibit) || (w_btn != r_last_btn));
        // A release report under inhibit carries no motion
        w_ox      = w_inhibit ? 8'sd0 : w_clamp_x;
        w_oy      = w_inhibit ? 8'sd0 : w_clamp_y;
        w_b0      = build_b0(w_btn, w_ox[7], w_oy[7]);
    end

    sat_axis_accum #(.ACC_W(ACC_W)) u_acc_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_inhibit),
        .i_add   (w_add),
        .i_delta (dx),
        .i_snap  (w_snap),
        .o_acc   (w_acc_x),
        .o_clamp (w_clamp_x)
    );

    sat_axis_accum #(.ACC_W(ACC_W)) u_acc_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_inhibit),
        .i_add   (w_add),
        .i_delta (dy),
        .i_snap  (w_snap),
        .o_acc   (w_acc_y),
        .o_clamp (w_clamp_y)
    );

    // Free-running report period timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Right-click latch: a new click wins over the snapshot clear so it is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_right_pend <= 1'b0;
        end else if (w_inhibit) begin
            r_right_pend <= 1'b0;
        end else if (right_click) begin
            r_right_pend <= 1'b1;
        end else if (w_snap && w_btn[BTN_R]) begin
            r_right_pend <= 1'b0;
        end
    end

    // Remember the buttons last reported to detect changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_btn <= 2'b00;
        end else if (w_snap) begin
            r_last_btn <= w_btn;
        end
    end

    // Report FSM with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ox      <= 8'h00;
            r_oy      <= 8'h00;
            r_m_data  <= 8'h00;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state <= SNAP;
                        r_busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    r_ox      <= w_ox;
                    r_oy      <= w_oy;
                    r_m_data  <= w_b0;
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b0;
                    r_state   <= B0;
                end
                B0: begin
                    if (m_ready) begin
                        r_m_data <= r_ox;
                        r_state  <= B1;
                    end
                end
                B1: begin
                    if (m_ready) begin
                        r_m_data <= r_oy;
                        r_m_last <= 1'b1;
                        r_state  <= B2;
                    end
                end
                B2: begin
                    if (m_ready) begin
                        r_m_data  <= 8'h00;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_m_data  <= 8'h00;
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign busy    = r_busy;

endmodule

// File: tb/tb_mouse_report_packer.sv
// Directed bench for mouse_report_packer: hand-computed report bytes are
// queued as expectations and compared against bytes accepted on the stream.
module tb_mouse_report_packer;

    localparam int REPORT_CYCLES = 64;
    localparam int ACC_W         = 12;
    localparam int WAIT_LIMIT    = 400;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] dx;
    logic [7:0] dy;
    logic       left_click;
    logic       right_click;
    logic [1:0] tier;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       busy;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    mouse_report_packer #(
        .REPORT_CYCLES (REPORT_CYCLES),
        .ACC_W         (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .dx           (dx),
        .dy           (dy),
        .left_click   (left_click),
        .right_click  (right_click),
        .tier         (tier),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted byte as {m_last, m_data}; inputs change only at posedge+1
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            got_q.push_back({m_last, m_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        dx           = 8'h00;
        dy           = 8'h00;
        left_click   = 1'b0;
        right_click  = 1'b0;
        tier         = 2'd0;
        m_ready      = 1'b1;
        repeat (2) step();
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic send_samples(input int n, input logic [7:0] sx, input logic [7:0] sy);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            dx           = sx;
            dy           = sy;
            step();
        end
        sample_valid = 1'b0;
        dx           = 8'h00;
        dy           = 8'h00;
    endtask

    task automatic expect_report(input string tag, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [7:0] b2);
        int waited;
        waited = 0;
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b1, b2});
        while (got_q.size() < 3 && waited < WAIT_LIMIT) begin
            step();
            waited++;
        end
        if (got_q.size() < 3) begin
            check({tag, "_timeout"}, got_q.size(), 3);
            got_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_b%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    task automatic check_none(input string tag, input int cycles);
        repeat (cycles) step();
        check(tag, got_q.size(), 0);
        got_q.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);

        // Five samples (+10, -3) -> one tick report 0x28 0x32 0xF1
        send_samples(5, 8'd10, 8'hFD);
        expect_report("t1_motion", 8'h28, 8'h32, 8'hF1);
        check_none("t1_acc_zero", 150);

        // 40 x +8 = 320 carries across three reports, fourth tick is silent
        do_reset();
        send_samples(40, 8'd8, 8'd0);
        expect_report("t2_r1", 8'h08, 8'h7F, 8'h00);
        expect_report("t2_r2", 8'h08, 8'h7F, 8'h00);
        expect_report("t2_r3", 8'h08, 8'h42, 8'h00);
        check_none("t2_idle", 150);

        // Left press mid-period: first byte two cycles after the change
        do_reset();
        repeat (10) step();
        left_click = 1'b1;
        step();
        check("t3_snap_busy", busy, 1);
        check("t3_snap_valid", m_valid, 0);
        step();
        check("t3_lat_valid", m_valid, 1);
        check("t3_lat_data", m_data, 8'h09);
        expect_report("t3_press", 8'h09, 8'h00, 8'h00);
        left_click = 1'b0;
        expect_report("t3_release", 8'h08, 8'h00, 8'h00);

        // Right click while stalled in byte 1 goes into the next report
        do_reset();
        send_samples(1, 8'd20, 8'd0);
        left_click = 1'b1;
        m_ready    = 1'b0;
        step();
        step();
        check("t4_b0_data", m_data, 8'h09);
        m_ready = 1'b1;
        step();
        m_ready     = 1'b0;
        right_click = 1'b1;
        step();
        right_click = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_data", m_data, 8'h14);
            check("t4_stall_valid", m_valid, 1);
            check("t4_stall_last", m_last, 0);
        end
        m_ready = 1'b1;
        expect_report("t4_cur", 8'h09, 8'h14, 8'h00);
        expect_report("t4_right", 8'h0B, 8'h00, 8'h00);
        expect_report("t4_unright", 8'h09, 8'h00, 8'h00);
        check_none("t4_idle", 150);

        // Tier inhibit: release report, samples and clicks ignored, resume later
        do_reset();
        left_click = 1'b1;
        expect_report("t5_press", 8'h09, 8'h00, 8'h00);
        send_samples(5, 8'd10, 8'd0);
        tier = 2'd2;
        expect_report("t5_release", 8'h08, 8'h00, 8'h00);
        send_samples(5, 8'd10, 8'd0);
        right_click = 1'b1;
        step();
        right_click = 1'b0;
        check_none("t5_inhibited", 150);
        tier = 2'd1;
        expect_report("t5_resume", 8'h09, 8'h00, 8'h00);
        left_click = 1'b0;
        expect_report("t5_unpress", 8'h08, 8'h00, 8'h00);

        // 21 x +100 saturates at 2047: sixteen reports of 127 then 15
        do_reset();
        send_samples(21, 8'd100, 8'd0);
        for (int i = 0; i < 16; i++) begin
            expect_report($sformatf("t6_sat%0d", i), 8'h08, 8'h7F, 8'h00);
        end
        expect_report("t6_tail", 8'h08, 8'h0F, 8'h00);

        // Reset asserted while stalled in byte 1 aborts the stream at once
        left_click = 1'b1;
        m_ready    = 1'b0;
        step();
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
        check("t6_pre_valid", m_valid, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_abort_valid", m_valid, 0);
        check("t6_abort_data", m_data, 0);
        check("t6_abort_last", m_last, 0);
        check("t6_abort_busy", busy, 0);
        left_click = 1'b0;
        m_ready    = 1'b1;
        step();
        got_q.delete();
        rst_n = 1'b1;
        check_none("t6_after_reset", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
